// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: rotating-priority arbiter granting one of N requesters until release.
// Optional forced release after MAX_HOLD cycles when GRANT_TIMEOUT_EN is defined.
module rr_grant_scheduler #(
  parameter int N        = 8,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           release_i,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           none,
  output logic           timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t         state_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q, ptr_q, pick_d, idx;
  logic           grant_valid_q, timeout_q, force_d, rel_d;
  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_d = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_q + IDW'(i);
      if (req[idx]) pick_d = idx;
    end
  end
`ifdef GRANT_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold_cnt_q;
  assign force_d = (state_q == GRANT) && (hold_cnt_q == HW'(MAX_HOLD - 1)) && !release_i && req[grant_id_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) hold_cnt_q <= '0;
    else hold_cnt_q <= (state_q == GRANT) ? hold_cnt_q + 1'b1 : '0;
`else
  assign force_d = 1'b0;
`endif
  assign rel_d = release_i | ~req[grant_id_q] | force_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        if (|req) begin
          state_q       <= GRANT;
          grant_q       <= {{(N-1){1'b0}}, 1'b1} << pick_d;
          grant_id_q    <= pick_d;
          grant_valid_q <= 1'b1;
        end
      end else if (rel_d) begin
        state_q       <= IDLE;
        grant_q       <= '0;
        grant_valid_q <= 1'b0;
        ptr_q         <= grant_id_q + 1'b1;
        timeout_q     <= force_d;
      end
    end
  end
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign none        = ~|req;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: directed and random checks of rr_grant_scheduler against a reference model.
module tb_rr_grant_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       release_i = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid, none, timeout;
  int n_chk = 0, n_fail = 0;
  bit m_valid, m_to;
  int m_id, m_ptr, m_hold;
  always #5 clk = ~clk;
  rr_grant_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .release_i(release_i),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid),
    .none(none), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_to = 0; m_id = 0; m_ptr = 0; m_hold = 0;
  endtask
  task automatic model_edge(input logic [7:0] r, input logic rl);
    bit found, forced;
    m_to = 0;
    if (!m_valid) begin
      found = 0;
      for (int o = 0; o < 8; o++)
        if (!found && r[(m_ptr + o) % 8]) begin
          found = 1;
          m_id = (m_ptr + o) % 8;
        end
      if (found) begin
        m_valid = 1;
        m_hold = 1;
      end
    end else begin
`ifdef GRANT_TIMEOUT_EN
      forced = (m_hold == 16) && !rl && r[m_id];
`else
      forced = 0;
`endif
      if (rl || !r[m_id] || forced) begin
        m_valid = 0;
        m_ptr = (m_id + 1) % 8;
        m_to = forced;
      end else m_hold++;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".grant"}, 32'(grant), m_valid ? 32'(1) << m_id : 32'h0);
    chk({tag, ".valid"}, 32'(grant_valid), 32'(m_valid));
    if (m_valid) chk({tag, ".id"}, 32'(grant_id), 32'(m_id));
    chk({tag, ".none"}, 32'(none), 32'(req == 8'h00));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask
  task automatic step(input string tag, input logic [7:0] r, input logic rl);
    req = r;
    release_i = rl;
    @(posedge clk);
    model_edge(r, rl);
    #1 check_all(tag);
  endtask
  task automatic do_reset(input logic [7:0] r);
    req = r;
    rst = 1'b1;
    #1 model_reset();
    check_all("reset");
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    logic [7:0] cur;
    int cyc, vcnt, tcnt;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all("reset_hold");
    chk("reset_none_ff", 32'(none), 32'h0);
    rst = 1'b0;
    step("first", 8'hFF, 1'b0);
    chk("first_grant", 32'(grant), 32'h01);
    for (int i = 1; i <= 8; i++) begin
      step("rot_rel", 8'hFF, 1'b1);
      chk("rot_idle", 32'(grant_valid), 32'h0);
      step("rot_gnt", 8'hFF, 1'b0);
      chk("rot_id", 32'(grant_id), 32'(i % 8));
    end
    do_reset(8'h20);
    step("to5", 8'h20, 1'b0);
    step("rel5", 8'h20, 1'b1);
    step("wrap0", 8'h05, 1'b0);
    chk("wrap_id0", 32'(grant_id), 32'h0);
    step("rel0", 8'h05, 1'b1);
    step("skip2", 8'h05, 1'b0);
    chk("skip_id2", 32'(grant_id), 32'h2);
    step("rel2", 8'h05, 1'b1);
    step("ptr3", 8'h08, 1'b0);
    chk("ptr3_id", 32'(grant_id), 32'h3);
    step("drop3", 8'h00, 1'b0);
    chk("drop_grant", 32'(grant), 32'h0);
    step("regrant3", 8'h08, 1'b0);
    step("rel_new4", 8'h18, 1'b1);
    chk("simul_idle", 32'(grant_valid), 32'h0);
    step("grant4", 8'h18, 1'b0);
    chk("grant4_vec", 32'(grant), 32'h10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_valid", 32'(grant_valid), 32'h0);
    @(negedge clk) rst = 1'b0;
    req = 8'h10;
    step("after_rst", 8'h10, 1'b0);
    chk("after_rst_id", 32'(grant_id), 32'h4);
`ifdef GRANT_TIMEOUT_EN
    do_reset(8'h02);
    vcnt = 0; tcnt = 0;
    step("to_start", 8'h02, 1'b0);
    for (int k = 0; k < 40 && grant_valid; k++) begin
      vcnt++;
      step("to_hold", 8'h02, 1'b0);
      if (timeout) tcnt++;
    end
    chk("to_len", 32'(vcnt), 32'd16);
    chk("to_pulses", 32'(tcnt), 32'd1);
    step("to_regrant", 8'h02, 1'b0);
    chk("to_regrant_id", 32'(grant_id), 32'h1);
`endif
    do_reset(8'h00);
    cur = 8'h00;
    for (cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 3) == 0) cur = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      step("rand", cur, $urandom_range(0, 5) == 0);
      chk("onehot", 32'($countones(grant) <= 1), 32'h1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
